// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serialiser between NUM_REQ byte-stream requesters.
// A grant covers a whole message (through req_last) so messages never interleave on txd.
module uart_tx_arb #(
  parameter int unsigned  NUM_REQ      = 4,
  parameter int unsigned  TIMEOUT_CLKS = 1024,
  localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS == 0) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [IDX_W-1:0] release_ptr;

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ for the first valid requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign release_ptr = IDX_W'((32'(grant_id_q) + 1) % NUM_REQ);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    idle_cnt_d = idle_cnt_q;
    tx_valid   = 1'b0;
    tx_data    = '0;
    req_ready  = '0;
    busy       = 1'b0;
    timeout    = 1'b0;

    unique case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        busy     = 1'b1;
        tx_valid = sel_valid;
        tx_data  = sel_valid ? sel_data : 8'h00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = tx_ready & (grant_id_q == IDX_W'(i));
        end

        if (sel_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != CntMax) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (sel_valid && tx_ready && sel_last) begin
          state_d  = StIdle;
          rr_ptr_d = release_ptr;
        end else if ((TIMEOUT_CLKS != 0) && !sel_valid && (idle_cnt_q == CntLast)) begin
          // Granted requester went quiet too long: release so others are not blocked.
          timeout  = 1'b1;
          state_d  = StIdle;
          rr_ptr_d = release_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign grant_id = grant_id_q;

endmodule
